vacc_dump: RTL and testbench

VACC_DUMP -- requirements
Module: vacc_dump

---
 rtl/vacc_dump.sv | 184 ++++++++++++++++++
 tb/tb_vacc_dump.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vacc_dump.sv
// Vector accumulator: sums N_FIELDS signed fields per address over acc_len passes
// and emits the final pass two cycles after the input word. Define VACC_DUMP_SAT_EN to saturate on overflow.
module vacc_dump #(
  parameter int N_FIELDS     = 8,
  parameter int IN_W         = 16,
  parameter int OUT_W        = 32,
  parameter int VECTOR_LEN   = 36,
  parameter int ACC_CNT_BITS = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sync_in,
  input  logic [N_FIELDS*IN_W-1:0]    acc_in,
  input  logic                        valid_in,
  input  logic [ACC_CNT_BITS-1:0]     acc_len,
  output logic [N_FIELDS*OUT_W-1:0]   dout,
  output logic                        dout_valid,
  output logic                        dout_last,
  output logic                        ovf
);

  localparam int AW = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
  localparam int WW = N_FIELDS * OUT_W;
  localparam int IW = N_FIELDS * IN_W;
  localparam logic [AW-1:0] ADDR_LAST = AW'(VECTOR_LEN - 1);

  typedef enum logic {WAIT_SYNC, RUN} state_t;

  state_t state_q, state_d;
  logic   accept;

  logic [ACC_CNT_BITS-1:0] len_q, len_d, pass_q, pass_d, len_eff, pass_cur;
  logic [AW-1:0]           addr_q, addr_d, addr_cur;
  logic                    is_last_addr, is_last_pass;

  logic          s1_valid_q, s1_first_q, s1_dump_q, s1_last_q;
  logic [IW-1:0] s1_data_q;
  logic [AW-1:0] s1_addr_q;

  logic [WW-1:0]       mem [VECTOR_LEN];
  logic [WW-1:0]       rd_q;
  logic [WW-1:0]       sum;
  logic [N_FIELDS-1:0] fovf;

  logic [WW-1:0] dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d, dout_last_q, dout_last_d, ovf_q, ovf_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WAIT_SYNC;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (sync_in) state_d = RUN;
  end

  // A word coinciding with sync_in already belongs to the new window.
  always_comb begin
    accept = valid_in && (sync_in || (state_q == RUN));
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    len_eff  = len_q;
    addr_cur = addr_q;
    pass_cur = pass_q;
    if (sync_in) begin
      len_eff  = (acc_len == '0) ? ACC_CNT_BITS'(1) : acc_len;
      addr_cur = '0;
      pass_cur = '0;
    end
  end

  assign is_last_addr = (addr_cur == ADDR_LAST);
  assign is_last_pass = (pass_cur == (len_eff - ACC_CNT_BITS'(1)));

  always_comb begin
    len_d  = len_eff;
    addr_d = addr_cur;
    pass_d = pass_cur;
    if (accept) begin
      if (is_last_addr) begin
        addr_d = '0;
        pass_d = is_last_pass ? '0 : pass_cur + ACC_CNT_BITS'(1);
      end else begin
        addr_d = addr_cur + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q      <= '0;
      addr_q     <= '0;
      pass_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_dump_q  <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_data_q  <= '0;
      s1_addr_q  <= '0;
    end else begin
      len_q      <= len_d;
      addr_q     <= addr_d;
      pass_q     <= pass_d;
      s1_valid_q <= accept;
      s1_first_q <= (pass_cur == '0);
      s1_dump_q  <= is_last_pass;
      s1_last_q  <= is_last_addr;
      s1_data_q  <= acc_in;
      s1_addr_q  <= addr_cur;
    end
  end

  // NOTE: storage is not reset; a pass-0 word never reads it, so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (s1_valid_q) mem[s1_addr_q] <= sum;
    if (s1_valid_q && (s1_addr_q == addr_cur)) rd_q <= sum;
    else                                       rd_q <= mem[addr_cur];
  end

  always_comb begin
    logic [OUT_W:0] prev, add, wide;
    sum  = '0;
    fovf = '0;
    prev = '0;
    add  = '0;
    wide = '0;
    for (int f = 0; f < N_FIELDS; f++) begin
      prev = s1_first_q ? '0
           : {rd_q[f*OUT_W + OUT_W - 1], rd_q[f*OUT_W +: OUT_W]};
      add  = {{(OUT_W + 1 - IN_W){s1_data_q[f*IN_W + IN_W - 1]}}, s1_data_q[f*IN_W +: IN_W]};
      wide = prev + add;
      fovf[f] = wide[OUT_W] ^ wide[OUT_W-1];
`ifdef VACC_DUMP_SAT_EN
      if (fovf[f]) sum[f*OUT_W +: OUT_W] = wide[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}}
                                                       : {1'b0, {(OUT_W-1){1'b1}}};
      else         sum[f*OUT_W +: OUT_W] = wide[OUT_W-1:0];
`else
      sum[f*OUT_W +: OUT_W] = wide[OUT_W-1:0];
`endif
    end
  end

  // A restart drops whatever old-window word is about to reach the output.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    dout_last_d  = 1'b0;
    ovf_d        = ovf_q;
    if (sync_in) begin
      ovf_d = 1'b0;
    end else if (s1_valid_q) begin
      if (|fovf) ovf_d = 1'b1;
      if (s1_dump_q) begin
        dout_d       = sum;
        dout_valid_d = 1'b1;
        dout_last_d  = s1_last_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      ovf_q        <= ovf_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_vacc_dump.sv
// Randomized self-checking bench for vacc_dump against a word-level accumulation model;
// a second narrow instance exercises overflow (wrap or VACC_DUMP_SAT_EN saturation).
module tb_vacc_dump;

  localparam int N  = 8;
  localparam int IW = 16;
  localparam int OW = 32;
  localparam int VL = 36;
  localparam int CB = 16;

  logic            clk, rst, sync_in, valid_in;
  logic [N*IW-1:0] acc_in;
  logic [CB-1:0]   acc_len;
  logic [N*OW-1:0] dout;
  logic            dout_valid, dout_last, ovf;

  logic        sync2, valid2, dv2, last2, ovf2;
  logic [31:0] acc2, dout2;
  logic [15:0] len2;

  vacc_dump #(.N_FIELDS(N), .IN_W(IW), .OUT_W(OW), .VECTOR_LEN(VL), .ACC_CNT_BITS(CB)) dut (
    .clk(clk), .rst(rst), .sync_in(sync_in), .acc_in(acc_in), .valid_in(valid_in),
    .acc_len(acc_len), .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last), .ovf(ovf)
  );

  vacc_dump #(.N_FIELDS(2), .IN_W(16), .OUT_W(16), .VECTOR_LEN(4), .ACC_CNT_BITS(16)) dut_ovf (
    .clk(clk), .rst(rst), .sync_in(sync2), .acc_in(acc2), .valid_in(valid2),
    .acc_len(len2), .dout(dout2), .dout_valid(dv2), .dout_last(last2), .ovf(ovf2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int dv_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: one accumulator row per vector address, expected dumps time-stamped.
  typedef struct {
    int              stamp;
    logic [N*OW-1:0] data;
    logic            last;
  } exp_t;

  exp_t            q[$];
  int              acc[VL][N];
  bit              m_run = 0;
  int              m_addr, m_pass, m_len;
  logic [N*OW-1:0] last_dout = '0;

  task automatic model_reset();
    m_run = 0;
    q.delete();
    last_dout = '0;
  endtask

  // Drives one cycle (called #1 after a rising edge) and advances the model for it.
  task automatic drive(input logic s, input logic v, input logic [N*IW-1:0] d,
                       input logic [CB-1:0] l);
    exp_t e;
    sync_in = s; valid_in = v; acc_in = d; acc_len = l;
    if (s) begin
      m_run = 1; m_addr = 0; m_pass = 0;
      m_len = (l == 0) ? 1 : int'(l);
      while (q.size() > 0 && q[q.size()-1].stamp >= cyc + 1) void'(q.pop_back());
    end
    if (v && m_run) begin
      for (int f = 0; f < N; f++) begin
        int x;
        x = int'($signed(d[f*IW +: IW]));
        acc[m_addr][f] = ((m_pass == 0) ? 0 : acc[m_addr][f]) + x;
        e.data[f*OW +: OW] = acc[m_addr][f];
      end
      if (m_pass == m_len - 1) begin
        e.stamp = cyc + 2;
        e.last  = (m_addr == VL - 1);
        q.push_back(e);
      end
      m_addr++;
      if (m_addr == VL) begin
        m_addr = 0;
        m_pass = (m_pass + 1) % m_len;
      end
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      bit   exp_v;
      exp_t e;
      exp_v = (q.size() > 0) && (q[0].stamp == cyc);
      check("dout_valid", dout_valid, exp_v);
      check("ovf", ovf, 1'b0);
      if (dout_valid) dv_cnt++;
      if (exp_v) begin
        e = q.pop_front();
        check("dout", dout, e.data);
        check("dout_last", dout_last, e.last);
        last_dout = e.data;
      end else begin
        check("dout_hold", dout, last_dout);
        check("dout_last_idle", dout_last, 1'b0);
      end
    end
  end

  function automatic logic [N*IW-1:0] word_k(input int k);
    logic [N*IW-1:0] w;
    for (int f = 0; f < N; f++) w[f*IW +: IW] = IW'(k);
    return w;
  endfunction

  function automatic logic [N*IW-1:0] rnd_word();
    logic [N*IW-1:0] w;
    for (int f = 0; f < N; f++) w[f*IW +: IW] = IW'($urandom);
    return w;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, '0, CB'($urandom));
  endtask

  initial begin
    int base, n2;
    bit saw_last;
    logic [31:0] exp2;
    clk = 0; rst = 1; sync_in = 0; valid_in = 0; acc_in = '0; acc_len = '0;
    sync2 = 0; valid2 = 0; acc2 = '0; len2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", dout, '0);
    check("rst_dout_valid", dout_valid, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    rst = 0;

    // Valid words before any sync are ignored.
    for (int i = 0; i < 10; i++) drive(0, 1, rnd_word(), CB'(1));

    // acc_len=1: every word dumps, signed values, last on word 35.
    drive(1, 0, '0, CB'(1));
    for (int i = 0; i < VL; i++) drive(0, 1, word_k(i - 10), CB'($urandom));
    idle(4);

    // acc_len=4, constant 3: dumps of 12 repeating with no new sync.
    base = dv_cnt;
    drive(1, 0, '0, CB'(4));
    for (int i = 0; i < 2 * 4 * VL; i++) drive(0, 1, word_k(3), CB'($urandom));
    idle(4);
    check("t2_dump_count", dv_cnt - base, 2 * VL);

    // acc_len=2, random data and random valid gaps, sync coinciding with a word.
    drive(1, 1, rnd_word(), CB'(2));
    for (int i = 0; i < 320; i++) drive(0, ($urandom % 10) < 7, rnd_word(), CB'($urandom));
    idle(4);

    // Restart at word 50 of an acc_len=3 window; new window dumps after 108 words.
    base = dv_cnt;
    drive(1, 0, '0, CB'(3));
    for (int i = 0; i < 50; i++) drive(0, 1, rnd_word(), CB'($urandom));
    drive(1, 1, rnd_word(), CB'(3));
    for (int i = 0; i < 3 * VL - 1; i++) drive(0, 1, rnd_word(), CB'($urandom));
    idle(4);
    check("t4_dump_count", dv_cnt - base, VL);

    // Restart in the middle of a dump; acc_len=0 behaves as 1.
    drive(1, 0, '0, CB'(1));
    for (int i = 0; i < 20; i++) drive(0, 1, rnd_word(), CB'($urandom));
    drive(1, 1, rnd_word(), CB'(0));
    for (int i = 0; i < VL + 5; i++) drive(0, 1, rnd_word(), CB'($urandom));
    idle(4);

    // Reset mid-dump: outputs clear at once and stay quiet until a new sync.
    drive(1, 0, '0, CB'(1));
    for (int i = 0; i < 10; i++) drive(0, 1, rnd_word(), CB'($urandom));
    rst = 1;
    model_reset();
    #1;
    check("t6_dout", dout, '0);
    check("t6_dout_valid", dout_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    base = dv_cnt;
    for (int i = 0; i < 40; i++) drive(0, 1, rnd_word(), CB'(1));
    idle(3);
    check("t6_quiet", dv_cnt - base, 0);
    drive(1, 0, '0, CB'(1));
    for (int i = 0; i < VL; i++) drive(0, 1, rnd_word(), CB'($urandom));
    idle(4);

    // Overflow on the 16-bit instance: 0x7FFF + 0x7FFF.
`ifdef VACC_DUMP_SAT_EN
    exp2 = {2{16'h7FFF}};
`else
    exp2 = {2{16'hFFFE}};
`endif
    for (int rep = 0; rep < 2; rep++) begin
      sync2 = 1; len2 = 16'd2; valid2 = 0;
      idle(1);
      sync2 = 0;
      idle(1);
      check("t5_ovf_cleared", ovf2, 1'b0);
      n2 = 0; saw_last = 0;
      for (int i = 0; i < 14; i++) begin
        valid2 = (i < 8);
        acc2 = {2{16'h7FFF}};
        idle(1);
        if (dv2) begin
          n2++;
          check("t5_dout", dout2, exp2);
          if (last2) saw_last = 1;
        end
      end
      valid2 = 0;
      check("t5_count", n2, 4);
      check("t5_last", saw_last, 1'b1);
      check("t5_ovf", ovf2, 1'b1);
      check("t5_hold", dout2, exp2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
